// File: rtl/dram_arb_pkg.sv
// Shared definitions for the CPU/DMA data-RAM arbiter.
package dram_arb_pkg;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned BURST_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DMA_LOCK = 2'd1,
        ST_RELEASE  = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Legal parameter ranges; the counters are sized to these limits.
    function automatic logic params_ok(int unsigned starve_limit, int unsigned max_burst);
        return (starve_limit >= 1) && (starve_limit <= 15) &&
               (max_burst >= 1) && (max_burst <= 255);
    endfunction

endpackage

// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the DMA master.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wen,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (!params_ok(STARVE_LIMIT, MAX_BURST)) begin : g_bad_params
        $error("dram_arbiter: STARVE_LIMIT or MAX_BURST out of range");
    end

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_BURST);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BURST_W-1:0]  burst_inc;
    logic                rd_pend_q;
    logic                rd_owner_q;
    logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;
    logic                idle_dma_wins;
    logic                cpu_gnt_raw, dma_gnt_raw;
    logic                cpu_gnt, dma_gnt;

    // Grant selection and next-state/counter computation.
    always_comb begin
        cpu_gnt_raw   = 1'b0;
        dma_gnt_raw   = 1'b0;
        state_d       = ST_IDLE;
        burst_d       = '0;
        burst_inc     = burst_q + BURST_W'(1);
        idle_dma_wins = dma_req & (~cpu_req | (starve_q == STARVE_MAX));

        unique case (state_q)
            ST_DMA_LOCK: begin
                if (dma_req && dma_lock) begin
                    dma_gnt_raw = 1'b1;
                    if (burst_inc == BURST_MAX) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_DMA_LOCK;
                        burst_d = burst_inc;
                    end
                end else begin
                    // Burst ended: arbitrate this very cycle as IDLE would.
                    cpu_gnt_raw = cpu_req & ~idle_dma_wins;
                    dma_gnt_raw = idle_dma_wins;
                end
            end
            ST_RELEASE: begin
                cpu_gnt_raw = cpu_req;
                dma_gnt_raw = ~cpu_req & dma_req;
            end
            default: begin
                cpu_gnt_raw = cpu_req & ~idle_dma_wins;
                dma_gnt_raw = idle_dma_wins;
                if (idle_dma_wins && dma_lock) begin
                    if (BURST_MAX == BURST_W'(1)) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_DMA_LOCK;
                        burst_d = BURST_W'(1);
                    end
                end
            end
        endcase

        // Nothing is granted while reset is held.
        cpu_gnt = cpu_gnt_raw & cpu_rst;
        dma_gnt = dma_gnt_raw & cpu_rst;

        starve_d = '0;
        if (dma_req && !dma_gnt) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
        end
    end

    assign cpu_ready  = cpu_gnt;
    assign dma_ready  = dma_gnt;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign mem_en     = cpu_gnt | dma_gnt;
    assign mem_wen    = (cpu_gnt & cpu_wen) | (dma_gnt & dma_wen);
    assign mem_addr   = cpu_gnt ? cpu_addr  : (dma_gnt ? dma_addr  : '0);
    assign mem_wdata  = cpu_gnt ? cpu_wdata : (dma_gnt ? dma_wdata : '0);

    assign cpu_rvalid = rd_pend_q & (rd_owner_q == PORT_CPU);
    assign dma_rvalid = rd_pend_q & (rd_owner_q == PORT_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

    // FSM, fairness counters, read-owner tracking and held read data.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            burst_q     <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= PORT_CPU;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            rd_pend_q  <= mem_en & ~mem_wen;
            rd_owner_q <= dma_gnt ? PORT_DMA : PORT_CPU;
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized scoreboard bench for dram_arbiter with a rule-level reference model.
module tb_dram_arbiter;

    localparam int ST_LIM = 4;
    localparam int MB     = 8;
    localparam int G_NONE = 0;
    localparam int G_CPU  = 1;
    localparam int G_DMA  = 2;
    localparam int M_IDLE = 0;
    localparam int M_BURST = 1;
    localparam int M_RELEASE = 2;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_wen = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ready, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_wen = 1'b0, dma_lock = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_ready, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 cpu_clk = ~cpu_clk;

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(ST_LIM), .MAX_BURST(MB)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM seen by the DUT, and the bench's own copy of what it should hold.
    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];

    always @(posedge cpu_clk) begin
        if (mem_en) begin
            if (mem_wen) ram[mem_addr[9:2]] <= mem_wdata;
            else         mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } ret_t;

    ret_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_cpu = '0, last_dma = '0;
    int          m_mode = M_IDLE, m_starve = 0, m_burst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who should own the RAM this cycle, from the arbitration rules.
    function automatic int model_grant(bit creq, bit dreq, bit dlock);
        if (m_mode == M_BURST && dreq && dlock) return G_DMA;
        if (m_mode == M_RELEASE) return creq ? G_CPU : (dreq ? G_DMA : G_NONE);
        if (creq && dreq) return (m_starve == ST_LIM) ? G_DMA : G_CPU;
        if (creq) return G_CPU;
        if (dreq) return G_DMA;
        return G_NONE;
    endfunction

    task automatic model_update(input bit dreq, input bit dlock, input int g);
        bit continuing;
        continuing = (m_mode == M_BURST) && dreq && dlock;
        if (dreq && g != G_DMA) m_starve = (m_starve + 1 > ST_LIM) ? ST_LIM : m_starve + 1;
        else                    m_starve = 0;
        if (continuing)                                          m_burst = m_burst + 1;
        else if (g == G_DMA && dlock && m_mode != M_RELEASE)     m_burst = 1;
        else                                                     m_burst = 0;
        if (m_burst == MB) begin
            m_mode  = M_RELEASE;
            m_burst = 0;
        end else if (m_burst > 0) begin
            m_mode = M_BURST;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    // One request cycle: apply inputs, check grant/RAM drive, advance the model.
    task automatic drive(input logic creq, input logic cwen, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwen,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input logic dlock, output int g);
        logic [31:0] ea, ed;
        logic        ew;
        @(negedge cpu_clk);
        cpu_req = creq; cpu_wen = cwen; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_wen = dwen; dma_addr = daddr; dma_wdata = dwd; dma_lock = dlock;
        #1;
        g  = model_grant(creq, dreq, dlock);
        ew = (g == G_CPU) ? cwen  : (g == G_DMA) ? dwen  : 1'b0;
        ea = (g == G_CPU) ? caddr : (g == G_DMA) ? daddr : 32'h0;
        ed = (g == G_CPU) ? cwd   : (g == G_DMA) ? dwd   : 32'h0;
        check("cpu_ready", 32'(cpu_ready), 32'(g == G_CPU));
        check("dma_ready", 32'(dma_ready), 32'(g == G_DMA));
        check("cpu_stall", 32'(cpu_stall), 32'(creq && g != G_CPU));
        check("mem_en",    32'(mem_en),    32'(g != G_NONE));
        check("mem_wen",   32'(mem_wen),   32'(ew));
        check("mem_addr",  mem_addr, ea);
        check("mem_wdata", mem_wdata, ed);
        if (g != G_NONE) begin
            if (ew) ref_mem[ea[9:2]] = ed;
            else    exp_q.push_back('{port: (g == G_DMA), data: ref_mem[ea[9:2]], due: cyc + 1});
        end
        model_update(dreq, dlock, g);
    endtask

    // Async reset with both masters requesting; release lands mid-cycle.
    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        cpu_addr = 32'h44; dma_addr = 32'h48;
        exp_q.delete();
        last_cpu = '0; last_dma = '0;
        m_mode = M_IDLE; m_starve = 0; m_burst = 0;
        #1;
        check("rst_cpu_ready",  32'(cpu_ready),  32'h0);
        check("rst_dma_ready",  32'(dma_ready),  32'h0);
        check("rst_mem_en",     32'(mem_en),     32'h0);
        check("rst_mem_wen",    32'(mem_wen),    32'h0);
        check("rst_mem_addr",   mem_addr,        32'h0);
        check("rst_mem_wdata",  mem_wdata,       32'h0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        check("rst_cpu_rdata",  cpu_rdata,       32'h0);
        check("rst_dma_rdata",  dma_rdata,       32'h0);
        repeat (2) @(posedge cpu_clk);
        #2;
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        cpu_rst = 1'b1;
    endtask

    // Return monitor: pops the scoreboard whenever a read is due or shows up.
    initial begin
        ret_t        e;
        bit          due;
        logic [31:0] got;
        forever begin
            @(posedge cpu_clk);
            cyc++;
            #4;
            if (mon_en) begin
                due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                check("rvalid_any", 32'(cpu_rvalid | dma_rvalid), 32'(due));
                if (due) begin
                    e = exp_q.pop_front();
                    check("ret_port_dma", 32'(dma_rvalid), 32'(e.port));
                    got = e.port ? dma_rdata : cpu_rdata;
                    check("ret_data", got, e.data);
                    if (e.port) last_dma = e.data;
                    else        last_cpu = e.data;
                end
                if (!cpu_rvalid) check("cpu_rdata_hold", cpu_rdata, last_cpu);
                if (!dma_rvalid) check("dma_rdata_hold", dma_rdata, last_dma);
            end
        end
    end

    initial begin
        int          g;
        logic [31:0] v;
        bit          cp, dp, cw, dw, dl;
        logic [31:0] ca, cd, da, dd;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[32'h100 >> 2]     = 32'hDEADBEEF;
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;

        do_reset();
        mon_en = 1'b1;

        // CPU-only read of 0x100.
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, g);
        check("cpu_only_grant", 32'(g), 32'(G_CPU));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        check("cpu_only_rvalid", 32'(cpu_rvalid), 32'h1);
        check("cpu_only_rdata", cpu_rdata, 32'hDEADBEEF);

        // Continuous contention without lock: four CPU grants, then one DMA.
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 32'(i * 4), 0, 1, 0, 32'(32'h200 + i * 4), 0, 0, g);
            check("starve_pattern", 32'(g), 32'((i % 5 == 4) ? G_DMA : G_CPU));
        end

        // Locked DMA burst against a busy CPU.
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 32'(32'h300 + i * 4), 0, 1, 1, 32'(32'h80 + i * 4), 32'($urandom), 1, g);
            check("burst_pattern", 32'(g), 32'((i >= 4 && i <= 11) ? G_DMA : G_CPU));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Alternating reads from the two ports.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, g);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, g);
        check("alt_dma_grant", 32'(g), 32'(G_DMA));
        drive(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, g);
        check("alt_cpu_grant", 32'(g), 32'(G_CPU));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Lock dropped at the third beat while the CPU waits.
        drive(0, 0, 0, 0, 1, 1, 32'h40, 32'h11, 1, g);
        drive(1, 0, 32'h50, 0, 1, 1, 32'h44, 32'h22, 1, g);
        check("drop_beat2", 32'(g), 32'(G_DMA));
        drive(1, 0, 32'h50, 0, 1, 1, 32'h48, 32'h33, 1, g);
        check("drop_beat3", 32'(g), 32'(G_DMA));
        drive(1, 0, 32'h50, 0, 1, 1, 32'h4C, 32'h44, 0, g);
        check("drop_cpu_same_cycle", 32'(g), 32'(G_CPU));
        drive(1, 0, 32'h54, 0, 1, 1, 32'h4C, 32'h44, 0, g);
        check("drop_back_in_idle", 32'(g), 32'(G_CPU));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Reset lands right after an accepted DMA read.
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, g);
        check("pre_reset_dma_read", 32'(g), 32'(G_DMA));
        do_reset();
        drive(1, 1, 32'h40, 32'hCAFE0040, 0, 0, 0, 0, 0, g);
        check("post_reset_cpu_write", 32'(g), 32'(G_CPU));
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, g);

        // Randomized traffic with the hold-until-ready handshake.
        cp = 0; dp = 0; cw = 0; dw = 0; dl = 0;
        ca = '0; cd = '0; da = '0; dd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1; cw = 1'($urandom_range(0, 1));
                ca = 32'($urandom_range(0, 255)) << 2; cd = $urandom;
            end else if (cp && $urandom_range(0, 15) == 0) begin
                cp = 0;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dw = 1'($urandom_range(0, 1));
                da = 32'($urandom_range(0, 255)) << 2; dd = $urandom;
            end else if (dp && $urandom_range(0, 15) == 0) begin
                dp = 0;
            end
            dl = ($urandom_range(0, 3) != 0);
            drive(cp, cw, ca, cd, dp, dw, da, dd, dl, g);
            if (g == G_CPU) cp = 0;
            if (g == G_DMA) dp = 0;
        end

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the CPU MEM stage and a DMA/program-loader master. It sits between `myCPU`'s data bus (`Bus_*`) and the DRAM IP. It sequences one access per cycle, routes registered read data back to the owning port and raises a stall for the pipeline while the CPU is waiting. A starvation counter and a bounded DMA burst lock guarantee forward progress for both masters.

## Interface
- `ADDR_W`, 32: address width, byte address passed through unchanged.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive denied DMA cycles before DMA is forced to win; legal range 1..15.
- `MAX_BURST`, 8: maximum consecutive locked DMA beats; legal range 1..255.

Ports:
- `cpu_clk` in 1: the single clock.
- `cpu_rst` in 1: reset, asynchronous and active-low.
- `cpu_req` in 1: CPU access request.
- `cpu_wen` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ready` out 1: CPU request accepted this cycle (combinational).
- `cpu_stall` out 1: `cpu_req & ~cpu_ready`; freezes the pipeline.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out DATA_W: CPU read data.
- `dma_req`, `dma_wen`, `dma_addr`, `dma_wdata`, `dma_ready`, `dma_rvalid`, `dma_rdata`: same meanings as the CPU signals, for the DMA port.
- `dma_lock` in 1: hold the grant for following beats (burst).
- `mem_en` out 1: RAM access enable.
- `mem_wen` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid one cycle after a read enable.

## Operation
- Each cycle at most one port is granted. The granted port's `*_ready`=1, and its `wen`/`addr`/`wdata` drive `mem_*` with `mem_en`=1. With no grant, `mem_*` are all 0.
- FSM states:
  - IDLE: CPU has priority.
  - DMA_LOCK: DMA has priority.
  - RELEASE: forced CPU priority for one cycle after a burst.
- IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: CPU wins, unless `starve_cnt == STARVE_LIMIT`, in which case DMA wins.
  - A DMA grant with `dma_lock`=1 moves to DMA_LOCK with `burst_cnt`=1.
- DMA_LOCK:
  - With `dma_req & dma_lock`: DMA is granted and `burst_cnt` increments.
  - When a granted beat brings `burst_cnt` to MAX_BURST, go to RELEASE.
  - `dma_req`=0 or `dma_lock`=0: go to IDLE in the same cycle; the CPU is arbitrated as in IDLE that cycle.
- RELEASE:
  - If `cpu_req`=1, the CPU is granted; otherwise the DMA may be granted (lock ignored).
  - Always go to IDLE next cycle.
- `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, each cycle `dma_req`=1 and DMA is not granted.
  - Clears on any DMA grant or when `dma_req`=0.
- Read return: on an accepted read, a 1-bit `rd_owner` and `rd_pend` are registered. Next cycle, the owner's `*_rvalid`=1 and its `*_rdata`=`mem_rdata`. The other port's `rdata` holds its last value.
- Writes complete on acceptance; there is no response.
- Back-to-back reads from alternating ports are legal; returns come in acceptance order, one per cycle.

## Timing
- Grant/ready: zero-cycle, combinational from the requests and the registered state/counters.
- Read latency: exactly 1 cycle from acceptance to `rvalid`.
- Throughput: 1 access per cycle.
- Handshake: requesters hold `req`/`addr`/`wdata` stable until `ready`. A request dropped before `ready` is legal and is simply never accepted.
- Reset (async assert, any cycle, including with a read in flight):
  - FSM goes to IDLE; `starve_cnt`, `burst_cnt`, `rd_pend` and `rd_owner` go to 0.
  - `*_rvalid`=0 and `*_rdata`=0; the in-flight return is discarded.
  - All `mem_*`=0 and both `ready`=0 while reset is held.
- Counter widths: `starve_cnt` 4 bits, `burst_cnt` 8 bits; neither wraps.

## Structure
- Shared package `dram_arb_pkg`: FSM state encoding (IDLE/DMA_LOCK/RELEASE), port ID constants (PORT_CPU=0, PORT_DMA=1), parameter range checks.
- No sub-module is required. The grant logic is one combinational block; the FSM, counters and read-owner tracking are one sequential block.
- In `myCPU`, `cpu_stall` feeds the existing `nop`/freeze path of the PC and pipeline registers.

## Test plan
- CPU only: read of 0x100 (RAM holds 0xDEADBEEF) -> `cpu_ready`=1 that cycle, `cpu_rvalid`=1 next cycle with `cpu_rdata`=0xDEADBEEF, `cpu_stall`=0.
- Both requesting continuously, STARVE_LIMIT=4, no lock -> CPU granted 4 cycles, DMA granted on the 5th, pattern repeats; `cpu_stall`=1 exactly on the DMA cycles.
- DMA burst with lock=1, MAX_BURST=8, CPU requesting throughout -> 8 consecutive DMA grants, then 1 CPU grant (RELEASE), then IDLE arbitration.
- Alternating reads CPU@0x10 / DMA@0x20 / CPU@0x30 -> each `rvalid` lands on the correct port one cycle after its acceptance, data matching RAM.
- Reset asserted the cycle after an accepted DMA read -> `dma_rvalid` stays 0, all outputs 0 immediately; after release, a CPU write to 0x40 is accepted in the first cycle.
- DMA drops `dma_lock` mid-burst at beat 3 with the CPU requesting -> CPU granted that same cycle, FSM in IDLE, `burst_cnt`=0.
